// File: rtl/raw_frame_packer.sv
// Capture-side write stage: packs four raw 8-bit Bayer pixels into one 32-bit word
// for frame-RAM port A, tracking frame boundaries and short/long frame errors.
module raw_frame_packer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 17
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_frame_start,
    input  logic              i_pix_valid,
    input  logic [7:0]        i_pix_data,
    output logic              o_we_a,
    output logic [ADDR_W-1:0] o_addr_a,
    output logic [31:0]       o_data_a,
    output logic              o_capturing,
    output logic              o_frame_done,
    output logic              o_short_frame,
    output logic              o_overrun,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_CAPTURE  = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam int                WORDS     = H_ACTIVE * V_ACTIVE / 4;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    state_t            r_state;
    logic [1:0]        r_lane;
    logic [ADDR_W-1:0] r_addr;
    logic [23:0]       r_buf;
    logic              r_complete;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr_a;
    logic [31:0]       r_data_a;
    logic              r_capturing;
    logic              r_frame_done;
    logic              r_short;
    logic              r_overrun;

    state_t            w_state;
    logic [1:0]        w_lane;
    logic [ADDR_W-1:0] w_addr;
    logic [23:0]       w_buf;
    logic              w_complete;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr_a;
    logic [31:0]       w_data_a;
    logic              w_frame_done;
    logic              w_short;
    logic              w_overrun;
    logic              w_restart;
    logic [1:0]        w_lane_base;
    logic [ADDR_W-1:0] w_addr_base;

    always_comb begin
        w_state      = r_state;
        w_lane       = r_lane;
        w_addr       = r_addr;
        w_buf        = r_buf;
        w_complete   = r_complete;
        w_we         = 1'b0;
        w_addr_a     = r_addr_a;
        w_data_a     = r_data_a;
        w_frame_done = 1'b0;
        w_short      = r_short;
        w_overrun    = r_overrun;
        w_restart    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_enable) w_state = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
                if (i_frame_start) begin
                    w_restart  = 1'b1;
                    w_state    = ST_CAPTURE;
                    w_short    = 1'b0;
                    w_overrun  = 1'b0;
                    w_complete = 1'b0;
                end else if (i_pix_valid && r_complete) begin
                    w_overrun = 1'b1;
                end
            end
            ST_CAPTURE: begin
                // A new frame_start mid-frame drops the partial word and restarts.
                if (i_frame_start) begin
                    w_restart = 1'b1;
                    w_short   = 1'b1;
                end
            end
            ST_DONE: begin
                w_state = i_enable ? ST_WAIT_SOF : ST_IDLE;
                if (i_pix_valid) w_overrun = 1'b1;
            end
            default: w_state = ST_IDLE;
        endcase

        w_lane_base = w_restart ? 2'd0 : r_lane;
        w_addr_base = w_restart ? '0 : r_addr;
        if (w_restart) begin
            w_lane = 2'd0;
            w_addr = '0;
        end

        if ((r_state == ST_CAPTURE || w_restart) && i_pix_valid) begin
            if (w_lane_base == 2'd3) begin
                w_we     = 1'b1;
                w_addr_a = w_addr_base;
                w_data_a = {i_pix_data, r_buf};
                w_lane   = 2'd0;
                if (w_addr_base == LAST_ADDR) begin
                    w_state      = ST_DONE;
                    w_frame_done = 1'b1;
                    w_complete   = 1'b1;
                end else begin
                    w_addr = w_addr_base + 1'b1;
                end
            end else begin
                case (w_lane_base)
                    2'd0:    w_buf[7:0]   = i_pix_data;
                    2'd1:    w_buf[15:8]  = i_pix_data;
                    default: w_buf[23:16] = i_pix_data;
                endcase
                w_lane = w_lane_base + 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lane       <= 2'd0;
            r_addr       <= '0;
            r_buf        <= 24'd0;
            r_complete   <= 1'b0;
            r_we         <= 1'b0;
            r_addr_a     <= '0;
            r_data_a     <= 32'd0;
            r_capturing  <= 1'b0;
            r_frame_done <= 1'b0;
            r_short      <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_lane       <= w_lane;
            r_addr       <= w_addr;
            r_buf        <= w_buf;
            r_complete   <= w_complete;
            r_we         <= w_we;
            r_addr_a     <= w_addr_a;
            r_data_a     <= w_data_a;
            r_capturing  <= (w_state == ST_CAPTURE);
            r_frame_done <= w_frame_done;
            r_short      <= w_short;
            r_overrun    <= w_overrun;
        end
    end

    assign o_we_a        = r_we;
    assign o_addr_a      = r_addr_a;
    assign o_data_a      = r_data_a;
    assign o_capturing   = r_capturing;
    assign o_frame_done  = r_frame_done;
    assign o_short_frame = r_short;
    assign o_overrun     = r_overrun;
    assign o_state       = r_state;

endmodule
